// File: rtl/vader_pkg.sv
// Shared encodings and defaults for the cracking datapath controller.
package vader_pkg;

    localparam logic [2:0] ST_WAIT    = 3'd0;
    localparam logic [2:0] ST_DICT    = 3'd1;
    localparam logic [2:0] ST_BRUTE   = 3'd2;
    localparam logic [2:0] ST_SUCCESS = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;

    typedef enum logic [2:0] {
        S_WAIT    = ST_WAIT,
        S_DICT    = ST_DICT,
        S_BRUTE   = ST_BRUTE,
        S_SUCCESS = ST_SUCCESS,
        S_FAIL    = ST_FAIL
    } top_state_t;

    // PH_LOAD is the extra dictionary cycle in which the BRAM word arrives.
    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_LOAD  = 2'd1,
        PH_OFFER = 2'd2,
        PH_AWAIT = 2'd3
    } phase_t;

    localparam int DEF_DICT_START     = 1;
    localparam int DEF_DICT_SIZE      = 10;
    localparam int DEF_BRUTE_ATTEMPTS = 100;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/brute_gen.sv
// Brute-force candidate counter: one step per verdict, flags the final attempt.
module brute_gen #(
    parameter int WORD_W         = 11,
    parameter int BRUTE_ATTEMPTS = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [WORD_W-1:0] value,
    output logic              last
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 32'd1;
        end
    end

    assign value = count[WORD_W-1:0];
    // High while the outstanding candidate is attempt number BRUTE_ATTEMPTS.
    assign last  = (count == 32'(BRUTE_ATTEMPTS - 1));

endmodule

// File: rtl/crack_sequencer.sv
// Top sequencer: dictionary walk over BRAM, then brute fallback, one candidate in flight.
module crack_sequencer
    import vader_pkg::*;
#(
    parameter int DICT_START     = DEF_DICT_START,
    parameter int DICT_SIZE      = DEF_DICT_SIZE,
    parameter int BRUTE_ATTEMPTS = DEF_BRUTE_ATTEMPTS,
    parameter int ADDR_W         = 8,
    parameter int WORD_W         = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_dout,
    output logic              cand_valid,
    input  logic              cand_ready,
    output logic [WORD_W-1:0] cand_data,
    input  logic              match_valid,
    input  logic              match,
    output logic [2:0]        state,
    output logic [WORD_W-1:0] found_word,
    output logic [31:0]       attempts
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DICT_SIZE - 1);
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DICT_START);

    top_state_t        st, st_n;
    phase_t            ph, ph_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic              cv_n;
    logic [WORD_W-1:0] cd_n, fw_n;
    logic [31:0]       att_n;
    logic              brute_clear, brute_adv, brute_last;
    logic [WORD_W-1:0] brute_value;

    brute_gen #(
        .WORD_W         (WORD_W),
        .BRUTE_ATTEMPTS (BRUTE_ATTEMPTS)
    ) u_brute_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (brute_clear),
        .advance (brute_adv),
        .value   (brute_value),
        .last    (brute_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            st         <= S_WAIT;
            ph         <= PH_FETCH;
            idx        <= '0;
            cand_valid <= 1'b0;
            cand_data  <= '0;
            found_word <= '0;
            attempts   <= '0;
        end else begin
            st         <= st_n;
            ph         <= ph_n;
            idx        <= idx_n;
            cand_valid <= cv_n;
            cand_data  <= cd_n;
            found_word <= fw_n;
            attempts   <= att_n;
        end
    end

    // Handshake: a candidate transfers on any edge where cand_valid & cand_ready;
    // cand_valid and cand_data hold until then, and match_valid counts only in AWAIT.
    always_comb begin
        st_n        = st;
        ph_n        = ph;
        idx_n       = idx;
        cv_n        = cand_valid;
        cd_n        = cand_data;
        fw_n        = found_word;
        att_n       = attempts;
        brute_clear = 1'b0;
        brute_adv   = 1'b0;
        case (st)
            S_WAIT: begin
                brute_clear = 1'b1;
                if (start) begin
                    st_n  = S_DICT;
                    ph_n  = PH_FETCH;
                    idx_n = '0;
                end
            end
            S_DICT: begin
                case (ph)
                    PH_FETCH: ph_n = PH_LOAD;
                    PH_LOAD: begin
                        cd_n = mem_dout;
                        cv_n = 1'b1;
                        ph_n = PH_OFFER;
                    end
                    PH_OFFER: begin
                        if (cand_ready) begin
                            cv_n  = 1'b0;
                            att_n = sat_inc(attempts);
                            ph_n  = PH_AWAIT;
                        end
                    end
                    default: begin
                        if (match_valid) begin
                            ph_n = PH_FETCH;
                            if (match) begin
                                st_n = S_SUCCESS;
                                fw_n = cand_data;
                            end else if (idx == LAST_IDX) begin
                                st_n = S_BRUTE;
                            end else begin
                                idx_n = idx + 1'b1;
                            end
                        end
                    end
                endcase
            end
            S_BRUTE: begin
                case (ph)
                    PH_OFFER: begin
                        if (cand_ready) begin
                            cv_n  = 1'b0;
                            att_n = sat_inc(attempts);
                            ph_n  = PH_AWAIT;
                        end
                    end
                    PH_AWAIT: begin
                        if (match_valid) begin
                            ph_n      = PH_FETCH;
                            brute_adv = 1'b1;
                            if (match) begin
                                st_n = S_SUCCESS;
                                fw_n = cand_data;
                            end else if (brute_last) begin
                                st_n = S_FAIL;
                            end
                        end
                    end
                    default: begin
                        cd_n = brute_value;
                        cv_n = 1'b1;
                        ph_n = PH_OFFER;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign mem_en   = (st == S_DICT) && (ph == PH_FETCH);
    assign mem_addr = mem_en ? (START_ADDR + idx) : '0;
    assign state    = st;

endmodule
